ifu: RTL
========

# ifu

Instruction fetch unit for the multi-cycle core. Holds the architectural PC, issues one word read per instruction to the instruction memory port over a valid/ready request and valid response interface, and hands the fetched `{pc, inst}` pair to the decode stage with a valid/ready handshake. It then waits for execute/writeback to return the next PC (sequential, jump or branch target) before fetching again. This replaces the combinational instruction-memory lookup in front of IDU.

## Interface
Parameters:
- `RESET_PC`, default `32'h8000_0000`: first fetch address after reset.

Ports:
- `clk`  in  1  clock; all state changes on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  out  1  fetch request valid.
- `req_ready`  in  1  memory accepts request.
- `req_addr`  out  32  word address; bits [1:0] always 0.
- `resp_valid`  in  1  read data valid, one-cycle pulse per accepted request.
- `resp_data`  in  32  instruction word.
- `out_valid`  out  1  instruction available to decode.
- `out_ready`  in  1  decode accepts instruction.
- `out_pc`  out  32  PC of presented instruction.
- `out_inst`  out  32  presented instruction word.
- `npc_valid`  in  1  next PC from writeback valid.
- `npc`  in  32  next PC value.
- `fetch_fault`  out  1  sticky misaligned-PC flag (see Configuration).

## Operation
- FSM states: `REQ`, `WAIT`, `HOLD`, `NPC`.
- `REQ`: `req_valid`=1, `req_addr`=pc. `req_valid` and `req_addr` stable until `req_ready`. On `req_valid & req_ready` -> `WAIT`.
- `WAIT`: on `resp_valid`, latch `resp_data` into `out_inst`, go to `HOLD`. `req_valid`=0.
- `HOLD`: `out_valid`=1, `out_pc`/`out_inst` stable. On `out_valid & out_ready` -> `NPC`.
- `NPC`: on `npc_valid`, pc <= `{npc[31:2],2'b00}`, go to `REQ`.
- `npc_valid` in any state other than `NPC` is ignored, including the fire cycle of `HOLD`. Writeback must present it no earlier than the cycle after the `out` handshake.
- `resp_valid` outside `WAIT` is ignored. At most one request is outstanding.
- `out_inst` holds its last value outside `HOLD`. Only `out_valid` qualifies it.

## Timing
- Reset (`rst`=1 at an edge): state <= `REQ`, pc <= `RESET_PC`, `out_inst` <= 0, `fetch_fault` <= 0. Resulting outputs: `req_valid`=1, `out_valid`=0.
- Reset mid-operation (any state, including an outstanding request) aborts it. A response arriving after reset is discarded because the state is `REQ`, not `WAIT`. Memory must drop in-flight reads on the same `rst`.
- Request fire at cycle t. Earliest `resp_valid` is t+1. `out_valid` is high from t+2.
- Best case is 4 cycles per instruction with zero-wait memory and immediate ready/npc: `REQ`, `WAIT`, `HOLD`, `NPC`.
- `out_valid` is registered (a state decode) with no combinational path from `out_ready`.
- `req_valid` has no combinational path from `req_ready`.

## Configuration
- `IFU_MISALIGN_CHECK_EN`
  - Defined: in `NPC`, if `npc_valid` and `npc[1:0]!=0`, set `fetch_fault`=1. It stays 1 until `rst`.
  - Fetch still proceeds at the address with bits [1:0] forced to 0.
- Not defined: `fetch_fault` is tied to 0 and low bits are silently dropped.

## Test plan
- Reset with `req_ready`=1 and a memory that returns `32'h00100073` one cycle later:
  - `req_addr`=`32'h8000_0000` in the first post-reset cycle.
  - `out_valid`=1 two cycles later with `out_pc`=`32'h8000_0000` and `out_inst`=`32'h00100073`.
- Backpressure: hold `req_ready`=0 for 3 cycles.
  - `req_valid`=1 and `req_addr` are unchanged throughout.
  - With `out_ready`=0 for 4 cycles, `out_valid`, `out_pc` and `out_inst` are stable.
- Sequential flow: return `npc`=`out_pc+4` for 3 instructions.
  - Fetch addresses are `8000_0000`, `8000_0004`, `8000_0008`.
  - Each instruction takes 4 cycles with a zero-wait memory.
- Jump: `npc`=`32'h8000_0100` -> next `req_addr`=`32'h8000_0100`.
- Ignored inputs:
  - `npc_valid` pulsed in `HOLD` with `npc`=`32'h1234` -> no effect; the later `npc` given in `NPC` is used.
  - Spurious `resp_valid` in `NPC` -> `out_inst` unchanged.
- `rst` asserted in `WAIT`, then a late `resp_valid`:
  - After reset, state is `REQ` at `RESET_PC` and `out_valid` stays 0.
  - With `IFU_MISALIGN_CHECK_EN` defined, `npc`=`32'h8000_0102` -> `fetch_fault`=1 and `req_addr`=`32'h8000_0100`.

Source files
------------

// File: rtl/ifu.sv
// Instruction fetch unit: one outstanding word fetch per instruction, {pc, inst} handoff to decode.
// Optional IFU_MISALIGN_CHECK_EN enables the sticky fetch_fault flag on misaligned next-PC.
module ifu #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        req_valid,
  input  logic        req_ready,
  output logic [31:0] req_addr,
  input  logic        resp_valid,
  input  logic [31:0] resp_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_inst,
  input  logic        npc_valid,
  input  logic [31:0] npc,
  output logic        fetch_fault
);

  typedef enum logic [1:0] {
    REQ  = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2,
    NPC  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;

  // Handshake outputs decode the state register only, so no ready-to-valid paths exist.
  assign req_valid = (state_q == REQ);
  assign req_addr  = pc_q;
  assign out_valid = (state_q == HOLD);
  assign out_pc    = pc_q;
  assign out_inst  = inst_q;

  // Next-state, PC and instruction-latch logic.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    inst_d  = inst_q;
    case (state_q)
      REQ: begin
        if (req_ready) begin
          state_d = WAIT;
        end else begin
          state_d = REQ;
        end
      end
      WAIT: begin
        if (resp_valid) begin
          inst_d  = resp_data;
          state_d = HOLD;
        end else begin
          state_d = WAIT;
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_d = NPC;
        end else begin
          state_d = HOLD;
        end
      end
      NPC: begin
        if (npc_valid) begin
          pc_d    = {npc[31:2], 2'b00};
          state_d = REQ;
        end else begin
          state_d = NPC;
        end
      end
      default: begin
        state_d = REQ;
      end
    endcase
  end

  // State, PC and instruction registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= REQ;
      pc_q    <= RESET_PC;
      inst_q  <= 32'h0000_0000;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
    end
  end

`ifdef IFU_MISALIGN_CHECK_EN
  logic fault_q, fault_d;

  // Sticky fault: set by a misaligned next-PC accepted in NPC, cleared only by reset.
  always_comb begin
    fault_d = fault_q;
    if ((state_q == NPC) && npc_valid && (npc[1:0] != 2'b00)) begin
      fault_d = 1'b1;
    end else begin
      fault_d = fault_q;
    end
  end

  // Fault flag register.
  always_ff @(posedge clk) begin
    if (rst) begin
      fault_q <= 1'b0;
    end else begin
      fault_q <= fault_d;
    end
  end

  assign fetch_fault = fault_q;
`else
  // Low next-PC bits are silently dropped in this build.
  logic unused_npc_lo;
  assign unused_npc_lo = ^npc[1:0];
  assign fetch_fault   = 1'b0;
`endif

endmodule
